// File: rtl/w5300_pkg.sv
// w5300_pkg: shared W5300 register-bus constants and arbiter state encoding
package w5300_pkg;
  localparam logic ADDR_OP_RD = 1'b1;
  localparam logic ADDR_OP_WR = 1'b0;
  localparam int CADDR_W = 11;
  localparam int DATA_W = 16;
  localparam logic [CADDR_W-1:0] CADDR_IDLE = 11'h400;
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, RESP} arb_state_t;
endpackage

// File: rtl/w5300_rw_arbiter_if.sv
// w5300_rw_arbiter_if: requester-side and engine-side bus of the W5300 register arbiter
interface w5300_rw_arbiter_if import w5300_pkg::*; #(parameter int N_REQ = 4) ();
  logic [N_REQ-1:0] req;
  logic [N_REQ*CADDR_W-1:0] req_caddr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] ack;
  logic [DATA_W-1:0] rsp_rdata;
  logic rsp_err;
  logic busy;
  logic [CADDR_W-1:0] caddr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic rw_ready;
  modport master (
    output req, req_caddr, req_wdata, rd_data, rw_ready,
    input gnt, ack, rsp_rdata, rsp_err, busy, caddr, wr_data
  );
  modport slave (
    input req, req_caddr, req_wdata, rd_data, rw_ready,
    output gnt, ack, rsp_rdata, rsp_err, busy, caddr, wr_data
  );
endinterface

// File: rtl/_w5300_rr_pick.sv
// _w5300_rr_pick: combinational round-robin picker, search starts just after last
module _w5300_rr_pick #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] win_oh,
  output logic [IW-1:0]    win_idx
);
  logic found;
  logic [IW-1:0] j;
  always_comb begin
    found = 1'b0;
    j = '0;
    win_idx = last;
    for (int k = 1; k <= N_REQ; k++) begin
      j = IW'((int'(last) + k) % N_REQ);
      if (!found && req[j]) begin
        found = 1'b1;
        win_idx = j;
      end
    end
    win_oh = found ? N_REQ'(1) << win_idx : '0;
  end
endmodule

// File: rtl/w5300_rw_arbiter.sv
// w5300_rw_arbiter: round-robin sequencer sharing the W5300 register read/write engine
module w5300_rw_arbiter import w5300_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst_n,
  w5300_rw_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  arb_state_t state;
  logic [IW-1:0] last, win_idx, pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic [CW-1:0] cnt;
  logic tmo;
  _w5300_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(bus.req),
    .last(last),
    .win_oh(pick_oh),
    .win_idx(pick_idx)
  );
  assign tmo = cnt == CW'(TIMEOUT);
  // Each wait phase owns the counter; it stops at TIMEOUT, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= IW'(N_REQ - 1);
      win_idx <= '0;
      cnt <= '0;
      bus.gnt <= '0;
      bus.ack <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
      bus.busy <= 1'b0;
      bus.caddr <= CADDR_IDLE;
      bus.wr_data <= '0;
    end else begin
      bus.ack <= '0;
      case (state)
        IDLE: if (|bus.req) begin
          state <= WAIT_BUSY;
          win_idx <= pick_idx;
          bus.gnt <= pick_oh;
          bus.caddr <= bus.req_caddr[pick_idx*CADDR_W +: CADDR_W];
          bus.wr_data <= bus.req_wdata[pick_idx*DATA_W +: DATA_W];
          bus.rsp_err <= 1'b0;
          bus.busy <= 1'b1;
          cnt <= '0;
        end
        WAIT_BUSY: if (!bus.rw_ready) begin
          cnt <= '0;
          state <= WAIT_DONE;
        end else if (tmo) begin
          bus.rsp_err <= 1'b1;
          bus.ack <= bus.gnt;
          bus.gnt <= '0;
          state <= RESP;
        end else cnt <= cnt + 1'b1;
        WAIT_DONE: if (bus.rw_ready) begin
          if (bus.caddr[CADDR_W-1] == ADDR_OP_RD) bus.rsp_rdata <= bus.rd_data;
          bus.ack <= bus.gnt;
          bus.gnt <= '0;
          state <= RESP;
        end else if (tmo) begin
          bus.rsp_err <= 1'b1;
          bus.ack <= bus.gnt;
          bus.gnt <= '0;
          state <= RESP;
        end else cnt <= cnt + 1'b1;
        RESP: begin
          last <= win_idx;
          bus.caddr <= CADDR_IDLE;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_w5300_rw_arbiter.sv
// tb_w5300_rw_arbiter: directed self-checking bench for the W5300 register arbiter
module tb_w5300_rw_arbiter;
  import w5300_pkg::*;
  localparam int N = 4;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int ncmp = 0;
  int nerr = 0;
  int idx [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  w5300_rw_arbiter_if #(.N_REQ(N)) bus ();
  w5300_rw_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic setreq(input int i, input logic [10:0] c, input logic [15:0] w);
    bus.req_caddr[i*11 +: 11] = c;
    bus.req_wdata[i*16 +: 16] = w;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, ".gnt"}, bus.gnt, 0);
    chk({tag, ".ack"}, bus.ack, 0);
    chk({tag, ".rdata"}, bus.rsp_rdata, 0);
    chk({tag, ".err"}, bus.rsp_err, 0);
    chk({tag, ".busy"}, bus.busy, 0);
    chk({tag, ".caddr"}, bus.caddr, 32'h400);
    chk({tag, ".wdata"}, bus.wr_data, 0);
  endtask
  // Called at the IDLE cycle in which req is sampled; engine goes busy one cycle, then done.
  task automatic access(input string tag, input logic [3:0] eg, input logic [10:0] ec,
                        input logic [15:0] ew, input logic [15:0] rd, input logic [15:0] erd,
                        input logic [3:0] drop);
    tick();
    chk({tag, ".gnt"}, bus.gnt, eg);
    chk({tag, ".busy"}, bus.busy, 1);
    chk({tag, ".caddr1"}, bus.caddr, ec);
    chk({tag, ".wdata1"}, bus.wr_data, ew);
    bus.req = bus.req & ~drop;
    bus.rw_ready = 1'b0;
    tick();
    chk({tag, ".noack"}, bus.ack, 0);
    chk({tag, ".caddr2"}, bus.caddr, ec);
    chk({tag, ".wdata2"}, bus.wr_data, ew);
    bus.rw_ready = 1'b1;
    bus.rd_data = rd;
    tick();
    chk({tag, ".ack"}, bus.ack, eg);
    chk({tag, ".rdata"}, bus.rsp_rdata, erd);
    chk({tag, ".err"}, bus.rsp_err, 0);
    chk({tag, ".gntclr"}, bus.gnt, 0);
    chk({tag, ".caddr3"}, bus.caddr, ec);
    chk({tag, ".wdata3"}, bus.wr_data, ew);
    tick();
    chk({tag, ".ackclr"}, bus.ack, 0);
    chk({tag, ".idle"}, bus.busy, 0);
    chk({tag, ".caddr_idle"}, bus.caddr, 32'h400);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req = '0;
    bus.req_caddr = '0;
    bus.req_wdata = '0;
    bus.rd_data = '0;
    bus.rw_ready = 1'b1;
    tick();
    tick();
    chk_reset("rst");
    rst_n = 1'b1;
    setreq(2, {ADDR_OP_RD, 10'h00A}, 16'h0000);
    bus.req = 4'b0100;
    access("rd", 4'b0100, 11'h40A, 16'h0000, 16'hBEEF, 16'hBEEF, 4'b0000);
    bus.req = '0;
    setreq(0, {ADDR_OP_WR, 10'h00C}, 16'h1234);
    bus.req = 4'b0001;
    access("wr", 4'b0001, 11'h00C, 16'h1234, 16'hDEAD, 16'hBEEF, 4'b0000);
    bus.req = '0;
    for (int i = 0; i < N; i++) setreq(i, 11'(11'h410 + i), 16'(i));
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++)
      access("rr", 4'(1 << idx[k]), 11'(11'h410 + idx[k]), 16'(idx[k]),
             16'(16'hA000 + k), 16'(16'hA000 + k), 4'b0000);
    bus.req = '0;
    setreq(1, 11'h401, 16'h0000);
    bus.req = 4'b0010;
    tick();
    chk("to.gnt", bus.gnt, 4'b0010);
    repeat (TO) begin
      tick();
      chk("to.wait", bus.ack, 0);
    end
    tick();
    chk("to.ack", bus.ack, 4'b0010);
    chk("to.err", bus.rsp_err, 1);
    bus.req = '0;
    tick();
    chk("to.errhold", bus.rsp_err, 1);
    bus.req = 4'b0010;
    access("to_next", 4'b0010, 11'h401, 16'h0000, 16'h5555, 16'h5555, 4'b0000);
    bus.req = '0;
    setreq(2, 11'h4AA, 16'h7777);
    bus.req = 4'b0100;
    tick();
    chk("mid.gnt", bus.gnt, 4'b0100);
    bus.rw_ready = 1'b0;
    tick();
    chk("mid.noack", bus.ack, 0);
    rst_n = 1'b0;
    #1;
    chk_reset("mid");
    bus.rw_ready = 1'b1;
    bus.rd_data = 16'h9999;
    tick();
    chk("mid.noack2", bus.ack, 0);
    tick();
    chk("mid.noack3", bus.ack, 0);
    chk("mid.nogrant", bus.gnt, 0);
    rst_n = 1'b1;
    bus.req = 4'b1111;
    access("post_rst", 4'b0001, 11'h410, 16'h0000, 16'h4321, 16'h4321, 4'b0000);
    bus.req = 4'b0010;
    access("drop", 4'b0010, 11'h401, 16'h0000, 16'h2468, 16'h2468, 4'b0010);
    repeat (3) begin
      tick();
      chk("drop.nogrant", bus.gnt, 0);
      chk("drop.noack", bus.ack, 0);
      chk("drop.idle", bus.busy, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
